// File: rtl/mix_columns_seq.sv
// -----------------------------------------------------------------------------
// mix_columns_seq
//
// Sequential AES MixColumns / InvMixColumns unit. One 128-bit state block is
// accepted through a valid/ready handshake. COLS_PER_CYCLE 32-bit columns are
// mixed per clock, so a block takes 4 / COLS_PER_CYCLE compute cycles. The
// result is held on out_data until the downstream stage takes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input block present
//   in_ready   unit can accept a block (high only in IDLE)
//   in_inv     0 = MixColumns, 1 = InvMixColumns; sampled with the block
//   in_data    state block, column 0 = [127:96] .. column 3 = [31:0],
//              byte b0 of each column is its most significant byte
//   out_valid  mixed result present
//   out_ready  downstream accepts the result
//   out_data   mixed state, same layout as in_data; shows intermediate
//              working values while a block is being processed
// -----------------------------------------------------------------------------
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  // Only 1, 2 or 4 columns per cycle divide the block into whole groups.
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int          N_GRPS   = 4 / COLS_PER_CYCLE;
  localparam logic [1:0]  GRP_LAST = 2'(N_GRPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [127:0]  work_q, work_d;
  logic          mode_q, mode_d;
  logic [1:0]    grp_q, grp_d;
  logic          in_ready_q;
  logic          out_valid_q;

  // GF(2^8) multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
  endfunction

  // Mix one 32-bit column; b0 sits in bits [31:24].
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  b  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [7:0]  m  [4];
    for (int i = 0; i < 4; i++) begin
      b[i]  = col[31 - 8*i -: 8];
      x2[i] = xtime(b[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int r = 0; r < 4; r++) begin
      if (inv) begin
        // Row r of the inverse matrix is (0e,0b,0d,09) rotated right by r.
        m[r] = (x8[r] ^ x4[r] ^ x2[r])                          // 0e
             ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ b[(r+1)%4])         // 0b
             ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ b[(r+2)%4])         // 0d
             ^ (x8[(r+3)%4] ^ b[(r+3)%4]);                      // 09
      end else begin
        // Row r of the forward matrix is (02,03,01,01) rotated right by r.
        m[r] = x2[r]
             ^ (x2[(r+1)%4] ^ b[(r+1)%4])
             ^ b[(r+2)%4]
             ^ b[(r+3)%4];
      end
    end
    return {m[0], m[1], m[2], m[3]};
  endfunction

  // Bit position of the MSB of the k-th column handled in group grp.
  function automatic int col_msb(input logic [1:0] grp, input int k);
    return 127 - 32 * ((int'(grp) * COLS_PER_CYCLE + k) % 4);
  endfunction

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    mode_d  = mode_q;
    grp_d   = grp_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_BUSY;
          work_d  = in_data;
          mode_d  = in_inv;
          grp_d   = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          work_d[col_msb(grp_q, k) -: 32] = mix_col(work_q[col_msb(grp_q, k) -: 32], mode_q);
        end
        if (grp_q == GRP_LAST) begin
          // Counter parks on the last group; it is cleared on the next accept.
          state_d = S_DONE;
        end else begin
          grp_d = grp_q + 2'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, working block and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      work_q      <= 128'd0;
      mode_q      <= 1'b0;
      grp_q       <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      mode_q      <= mode_d;
      grp_q       <= grp_d;
      // Flags are a registered copy of the next state, so they track state only.
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// -----------------------------------------------------------------------------
// tb_mix_columns_seq
//
// Self-checking bench for mix_columns_seq. Three instances (1, 2 and 4 columns
// per cycle) share the input side; most scenarios observe the single-column
// instance. Expected values come from a GF(2^8) matrix model built on a
// generic shift-and-reduce multiplier.
// -----------------------------------------------------------------------------
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_inv;
  logic [127:0] in_data;
  logic         out_ready;

  logic         rdy1, rdy2, rdy4;
  logic         ov1, ov2, ov4;
  logic [127:0] od1, od2, od4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_inv(in_inv),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1));
  mix_columns_seq #(.COLS_PER_CYCLE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_inv(in_inv),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2));
  mix_columns_seq #(.COLS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4), .in_inv(in_inv),
    .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4));

  // ---------------------------------------------------------------- model
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'd0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] blk, input bit inv);
    logic [7:0]   coef [4];
    logic [7:0]   bt   [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    res = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) bt[j] = blk[127 - 32*c - 8*j -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - r + 4) % 4], bt[j]);
        res[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_inv    = 1'b0;
    out_ready = 1'b0;
    in_data   = 128'd0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Push one block through u1 and take its result; lat = edges from accept to out_valid.
  task automatic run_block(input logic [127:0] d, input bit inv, input bit stall,
                           input bit toggle, output logic [127:0] res,
                           output int lat, output bit ok);
    int w;
    ok  = 1'b1;
    lat = 0;
    res = 128'd0;
    w   = 0;
    in_data  = d;
    in_inv   = inv;
    in_valid = 1'b1;
    if (!stall) out_ready = 1'b1;
    while (!rdy1 && w < 50) begin
      tick();
      w++;
    end
    if (!rdy1) begin
      in_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    while (!ov1 && lat < 50) begin
      if (stall) out_ready = 1'($urandom_range(0, 1));
      if (toggle) in_inv = ~in_inv;
      tick();
      lat++;
    end
    if (!ov1) begin
      ok = 1'b0;
      return;
    end
    if (stall) begin
      out_ready = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    res = od1;
    out_ready = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0; in_data = 128'd0;
    rst_n = 1'b0;
    tick();
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", rdy1); end
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov1); end
    checks++; if (od1 !== 128'd0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", od1); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    checks++; if (rdy1 !== 1'b1 || ov1 !== 1'b0) begin errors++; $display("FAIL reset_idle_after_release: got rdy=%b ov=%b expected rdy=1 ov=0", rdy1, ov1); end
  endtask

  task automatic test_forward_c1();
    logic [127:0] res;
    int lat;
    bit ok;
    run_block(128'hdb135345_f20a225c_01010101_2d26314c, 1'b0, 1'b0, 1'b0, res, lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fwd_timeout: got no handshake expected completion"); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL fwd_latency: got %0d expected 4", lat); end
    checks++; if (res !== 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8) begin errors++; $display("FAIL fwd_data: got %h expected 8e4da1bc9fdc589d010101014d7ebdf8", res); end
    checks++; if (rdy1 !== 1'b1 || ov1 !== 1'b0) begin errors++; $display("FAIL fwd_ready_again: got rdy=%b ov=%b expected rdy=1 ov=0", rdy1, ov1); end
  endtask

  task automatic test_inverse_all_c();
    logic [127:0] exp_d, d1, d2, d4;
    int l1, l2, l4;
    exp_d = 128'hdb135345_f20a225c_01010101_2d26314c;
    do_reset();
    l1 = -1; l2 = -1; l4 = -1;
    d1 = 128'd0; d2 = 128'd0; d4 = 128'd0;
    in_data   = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    in_inv    = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    checks++; if ({rdy1, rdy2, rdy4} !== 3'b111) begin errors++; $display("FAIL inv_ready_before: got %b expected 111", {rdy1, rdy2, rdy4}); end
    tick();
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      if (ov1 && l1 < 0) begin l1 = cyc; d1 = od1; end
      if (ov2 && l2 < 0) begin l2 = cyc; d2 = od2; end
      if (ov4 && l4 < 0) begin l4 = cyc; d4 = od4; end
    end
    checks++; if (l1 !== 4) begin errors++; $display("FAIL inv_latency_c1: got %0d expected 4", l1); end
    checks++; if (l2 !== 2) begin errors++; $display("FAIL inv_latency_c2: got %0d expected 2", l2); end
    checks++; if (l4 !== 1) begin errors++; $display("FAIL inv_latency_c4: got %0d expected 1", l4); end
    checks++; if (d1 !== exp_d) begin errors++; $display("FAIL inv_data_c1: got %h expected %h", d1, exp_d); end
    checks++; if (d2 !== exp_d) begin errors++; $display("FAIL inv_data_c2: got %h expected %h", d2, exp_d); end
    checks++; if (d4 !== exp_d) begin errors++; $display("FAIL inv_data_c4: got %h expected %h", d4, exp_d); end
    in_inv = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [127:0] exp_d;
    int w;
    exp_d = 128'hc6c6c6c6_d5d5d7d6_01010101_4d7ebdf8;
    out_ready = 1'b0;
    in_data   = 128'hc6c6c6c6_d4d4d4d5_01010101_2d26314c;
    in_inv    = 1'b0;
    in_valid  = 1'b1;
    w = 0;
    while (!rdy1 && w < 50) begin tick(); w++; end
    tick();
    in_valid = 1'b0;
    w = 0;
    while (!ov1 && w < 50) begin tick(); w++; end
    checks++; if (w !== 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", w); end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        in_data  = 128'h01234567_89abcdef_fedcba98_76543210;
      end
      if (i == 4) in_valid = 1'b0;
      checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc%0d: got %b expected 1", i, ov1); end
      checks++; if (od1 !== exp_d) begin errors++; $display("FAIL bp_out_data cyc%0d: got %h expected %h", i, od1, exp_d); end
      checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d: got %b expected 0", i, rdy1); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++; if (rdy1 !== 1'b1 || ov1 !== 1'b0) begin errors++; $display("FAIL bp_release: got rdy=%b ov=%b expected rdy=1 ov=0", rdy1, ov1); end
    repeat (6) tick();
    checks++; if (ov1 !== 1'b0 || rdy1 !== 1'b1) begin errors++; $display("FAIL bp_second_block_ignored: got rdy=%b ov=%b expected rdy=1 ov=0", rdy1, ov1); end
  endtask

  task automatic test_mode_latch();
    logic [127:0] d, res, exp_d;
    int lat;
    bit ok;
    d = {$urandom, $urandom, $urandom, $urandom};
    exp_d = ref_mix(d, 1'b0);
    run_block(d, 1'b0, 1'b0, 1'b1, res, lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mode_latch_timeout: got no handshake expected completion"); end
    checks++; if (res !== exp_d) begin errors++; $display("FAIL mode_latch_data: got %h expected %h", res, exp_d); end
    in_inv = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [127:0] d, res, exp_d;
    int lat, w;
    bit ok;
    out_ready = 1'b1;
    in_data   = 128'h00112233_44556677_8899aabb_ccddeeff;
    in_inv    = 1'b0;
    in_valid  = 1'b1;
    w = 0;
    while (!rdy1 && w < 50) begin tick(); w++; end
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", rdy1); end
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", ov1); end
    checks++; if (od1 !== 128'd0) begin errors++; $display("FAIL midrst_out_data: got %h expected 0", od1); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    d = {$urandom, $urandom, $urandom, $urandom};
    exp_d = ref_mix(d, 1'b0);
    run_block(d, 1'b0, 1'b0, 1'b0, res, lat, ok);
    checks++; if (!ok || lat !== 4) begin errors++; $display("FAIL midrst_next_latency: got %0d (ok=%b) expected 4", lat, ok); end
    checks++; if (res !== exp_d) begin errors++; $display("FAIL midrst_next_data: got %h expected %h", res, exp_d); end
  endtask

  task automatic test_random_roundtrip();
    logic [127:0] d, f, b;
    int lat;
    bit ok;
    for (int n = 0; n < 1000; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      run_block(d, 1'b0, 1'b1, 1'b0, f, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rt_fwd_timeout blk%0d: got no handshake expected completion", n); end
      checks++; if (f !== ref_mix(d, 1'b0)) begin errors++; $display("FAIL rt_fwd_model blk%0d: got %h expected %h", n, f, ref_mix(d, 1'b0)); end
      run_block(f, 1'b1, 1'b1, 1'b0, b, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rt_inv_timeout blk%0d: got no handshake expected completion", n); end
      checks++; if (b !== d) begin errors++; $display("FAIL rt_roundtrip blk%0d: got %h expected %h", n, b, d); end
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_forward_c1();
    test_inverse_all_c();
    test_backpressure();
    test_mode_latch();
    test_reset_mid();
    test_random_roundtrip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mix_columns_seq.md
# mix_columns_seq

Sequential, parametrised AES MixColumns / InvMixColumns unit with valid/ready handshakes on input and output. It accepts one 128-bit state block, processes COLS_PER_CYCLE 32-bit columns per clock, and holds the result until the downstream stage takes it. It replaces the purely combinational column mixer in the round datapath. Throughput and area are traded through one parameter, and a runtime mode selects encryption or decryption.

## Interface
- COLS_PER_CYCLE, 1: columns processed per cycle; legal values are 1, 2 and 4. Any other value must fail elaboration.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input block present
- in_ready  output  1  unit can accept a block
- in_inv  input  1  0 = MixColumns, 1 = InvMixColumns; sampled with the block
- in_data  input  128  state block; column 0 = [127:96] … column 3 = [31:0]; within a column, byte b0 = MSB
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts the result
- out_data  output  128  mixed state, same column/byte layout as in_data

## Operation
- States:
  - IDLE: in_ready = 1.
  - BUSY: internal group counter grp counts 0 … N-1, where N = 4 / COLS_PER_CYCLE.
  - DONE: out_valid = 1.
- Transitions:
  - IDLE → BUSY on in_valid && in_ready. Latch in_data into the working register, latch in_inv into mode, set grp = 0.
  - BUSY: each cycle, replace columns grp·C … grp·C+C-1 (C = COLS_PER_CYCLE) with their mixed value. grp increments by 1. After group N-1, go to DONE. The counter does not wrap past N-1.
  - DONE → IDLE on out_ready. Out_data stays stable while out_valid && !out_ready.
- Forward column mix, with all arithmetic in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11b):
  - mb0 = 2b0^3b1^b2^b3
  - mb1 = b0^2b1^3b2^b3
  - mb2 = b0^b1^2b2^3b3
  - mb3 = 3b0^b1^b2^2b3
- Inverse column mix uses the circulant matrix rows (0e,0b,0d,09), (09,0e,0b,0d), (0d,09,0e,0b), (0b,0d,09,0e).
- xtime(x) = {x[6:0],0} ^ (0x1b & {8{x[7]}}). Products by 0x09, 0x0b, 0x0d and 0x0e are built from xtime chains and XOR only; no table lookups.
- Mode applies to the whole block. Changes on in_inv while the unit is not in IDLE are ignored.
- in_valid while the unit is not in IDLE is ignored; the block is not accepted or dropped. The upstream stage must hold it until in_ready.
- Only one block is in flight at a time.
- Reset, asynchronous, at any point:
  - state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, grp = 0, mode = 0.
  - Any partially processed block is discarded.
- On release of rst_n, the first acceptance can occur at the first rising edge with in_valid high.

## Timing
- Acceptance edge = cycle 0. out_valid rises after the edge at cycle N: 4 cycles for C=1, 2 for C=2, 1 for C=4.
- The DONE → IDLE handshake edge clears out_valid and sets in_ready in the same cycle.
- Minimum block period is N+2 cycles: accept, N compute cycles, handshake, then in_ready is seen high.
- out_data is registered, with no combinational path from any input to any output.
- in_ready depends only on state.
- Output reset values: in_ready = 1, out_valid = 0, out_data = 0.
- out_data shows intermediate working values while BUSY. It is meaningful only when out_valid = 1.

## Test plan
- Forward, C=1:
  - Stimulus: in_data = db135345_f20a225c_01010101_2d26314c, in_inv = 0, out_ready held high.
  - Required: out_valid exactly 4 cycles after acceptance, out_data = 8e4da1bc_9fdc589d_01010101_4d7ebdf8, in_ready high again 1 cycle later.
- Inverse, all C in {1,2,4}:
  - Stimulus: in_data = 8e4da1bc_9fdc589d_01010101_4d7ebdf8, in_inv = 1.
  - Required: out_data = db135345_f20a225c_01010101_2d26314c, with latency 4, 2 and 1 cycles respectively.
- Backpressure:
  - Stimulus: in_data = c6c6c6c6_d4d4d4d5_01010101_2d26314c, in_inv = 0, out_ready low for 10 cycles.
  - Required: out_valid and out_data = c6c6c6c6_d5d5d7d6_01010101_4d7ebdf8 held stable throughout, and in_ready stays 0.
  - Required: a second in_valid pulse during this time is not accepted.
- Mode latching:
  - Stimulus: accept a block with in_inv = 0, then toggle in_inv every cycle while BUSY.
  - Required: the result equals the forward mix.
- Reset mid-operation, C=1:
  - Stimulus: assert rst_n low asynchronously with grp = 2.
  - Required: outputs immediately in_ready = 1, out_valid = 0, out_data = 0.
  - Required: the next block processes correctly with full 4-cycle latency.
- Random round-trip:
  - Stimulus: 1000 random blocks in forward mode, each result fed back in inverse mode, with random out_ready stalls.
  - Required: every round trip returns the original block.
  - Required: forward results match a GF(2^8) reference model.
